led_pwm_driver: RTL and testbench

- Downstream consumer of the microcode sequencer.
- Takes the 12-bit LED enable vector and two 4-bit PWM duty levels each time the sequencer fetches a new microinstruction.
- Drives 12 physical LED pins with glitch-free PWM.
- New values are double-buffered and applied only at a PWM period boundary, so a mid-period microcode update never truncates or stretches a pulse.

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_pwm_timebase.sv | 48 ++++
 rtl/led_pwm_driver.sv | 101 ++++++++++
 tb/tb_led_pwm_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared sizes and types for the LED PWM driver.
// The duty-step helper exists only when LED_PWM_FADE_EN is defined.
package led_pkg;
  localparam int LED_COUNT = 12;
  localparam int DUTY_W    = 4;
  localparam int PWM_STEPS = 16;

  typedef logic [DUTY_W:1]    duty_t;
  typedef logic [LED_COUNT:1] led_vec_t;

`ifdef LED_PWM_FADE_EN
  // Move one duty level toward the target, never overshooting it.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    if (cur < tgt)
      return duty_t'(cur + duty_t'(1));
    else if (cur > tgt)
      return duty_t'(cur - duty_t'(1));
    else
      return cur;
  endfunction
`endif
endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: a prescaler that produces a step tick, and a 4-bit step counter
// whose 15->0 wrap marks the PWM period boundary.
module led_pwm_timebase
  import led_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          tick,
  output logic          boundary,
  output logic [DUTY_W:1] pwm_cnt
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  duty_t pwm_cnt_reg;

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      logic [PW-1:0] presc_reg;

      assign tick = (presc_reg == PW'(PRESCALE - 1));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          presc_reg <= '0;
        else if (tick)
          presc_reg <= '0;
        else
          presc_reg <= presc_reg + PW'(1);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pwm_cnt_reg <= '0;
    else if (tick)
      pwm_cnt_reg <= pwm_cnt_reg + duty_t'(1);
  end

  assign pwm_cnt  = pwm_cnt_reg;
  assign boundary = tick && (pwm_cnt_reg == duty_t'(PWM_STEPS - 1));

endmodule

// File: rtl/led_pwm_driver.sv
// 12-LED PWM driver with double-buffered enable/duty values applied at period boundaries.
// Define LED_PWM_FADE_EN to ramp active duties by one level per period instead of jumping.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int PRESCALE = 16,
  parameter int SPLIT    = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [LED_COUNT:1]   vec_in,
  input  logic [DUTY_W:1]      duty1,
  input  logic [DUTY_W:1]      duty2,
  output logic [LED_COUNT:1]   led,
  output logic                 period_start,
  output logic                 pending
);

  logic     tick;
  logic     boundary;
  duty_t    pwm_cnt;

  led_vec_t shadow_vec_reg, act_vec_reg, led_reg;
  duty_t    shadow_d1_reg, shadow_d2_reg, act_d1_reg, act_d2_reg;
  logic     pending_reg, period_start_reg;

  led_vec_t tgt_vec, led_next;
  duty_t    tgt_d1, tgt_d2, next_d1, next_d2;
  logic     apply_now, settled;

  led_pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .boundary (boundary),
    .pwm_cnt  (pwm_cnt)
  );

  // A load coinciding with the boundary bypasses the shadow and targets the inputs directly.
  assign tgt_vec   = load ? vec_in : shadow_vec_reg;
  assign tgt_d1    = load ? duty1  : shadow_d1_reg;
  assign tgt_d2    = load ? duty2  : shadow_d2_reg;
  assign apply_now = tick && boundary && (load || pending_reg);

`ifdef LED_PWM_FADE_EN
  assign next_d1 = step_toward(act_d1_reg, tgt_d1);
  assign next_d2 = step_toward(act_d2_reg, tgt_d2);
  assign settled = (next_d1 == tgt_d1) && (next_d2 == tgt_d2);
`else
  assign next_d1 = tgt_d1;
  assign next_d2 = tgt_d2;
  assign settled = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_vec_reg   <= '0;
      shadow_d1_reg    <= '0;
      shadow_d2_reg    <= '0;
      act_vec_reg      <= '0;
      act_d1_reg       <= '0;
      act_d2_reg       <= '0;
      pending_reg      <= 1'b0;
      period_start_reg <= 1'b0;
      led_reg          <= '0;
    end else begin
      period_start_reg <= boundary;
      led_reg          <= led_next;
      if (load) begin
        shadow_vec_reg <= vec_in;
        shadow_d1_reg  <= duty1;
        shadow_d2_reg  <= duty2;
      end
      if (apply_now) begin
        act_vec_reg <= tgt_vec;
        act_d1_reg  <= next_d1;
        act_d2_reg  <= next_d2;
        pending_reg <= !settled;
      end else if (load) begin
        pending_reg <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= LED_COUNT; gi++) begin : g_led
      if (gi <= SPLIT) begin : g_ch1
        assign led_next[gi] = act_vec_reg[gi] && (pwm_cnt < act_d1_reg);
      end else begin : g_ch2
        assign led_next[gi] = act_vec_reg[gi] && (pwm_cnt < act_d2_reg);
      end
    end
  endgenerate

  assign led          = led_reg;
  assign period_start = period_start_reg;
  assign pending      = pending_reg;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver (PRESCALE=1, 16-clk periods).
// Expected per-step LED patterns are queued at load time and popped as the DUT drives them.
module tb_led_pwm_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [12:1] vec_in = '0;
  logic [4:1]  duty1 = '0;
  logic [4:1]  duty2 = '0;
  logic [12:1] led;
  logic        period_start;
  logic        pending;

  int checks = 0;
  int passes = 0;
  logic [12:1] sb[$];

  led_pwm_driver #(.PRESCALE(1), .SPLIT(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .vec_in       (vec_in),
    .duty1        (duty1),
    .duty2        (duty2),
    .led          (led),
    .period_start (period_start),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout led=%h required=finish", led);
    $fatal(1, "timeout");
  end

  function automatic logic [12:1] exp_led(input logic [12:1] v, input int d1, input int d2, input int k);
    logic [12:1] r;
    for (int i = 1; i <= 12; i++) begin
      int d;
      d = (i <= 6) ? d1 : d2;
      r[i] = v[i] && (k < d);
    end
    return r;
  endfunction

  task automatic push_period(input logic [12:1] v, input int d1, input int d2);
    for (int k = 0; k < 16; k++) sb.push_back(exp_led(v, d1, d2, k));
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 64);
    if (period_start !== 1'b1) begin
      checks++;
      $display("FAIL wait_period_start period_start=%b required=1 within 64 clk", period_start);
    end
  endtask

  task automatic do_load(input logic [12:1] v, input logic [4:1] d1, input logic [4:1] d2);
    vec_in = v; duty1 = d1; duty2 = d2; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("load vec=%h duty1=%0d duty2=%0d", v, d1, d2);
  endtask

  task automatic test_reset();
    logic [12:1] e;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (led !== 12'h000) $display("FAIL reset_led got=%h exp=000", led); else passes++;
    checks++; if (pending !== 1'b0) $display("FAIL reset_pending got=%b exp=0", pending); else passes++;
    checks++; if (period_start !== 1'b0) $display("FAIL reset_ps got=%b exp=0", period_start); else passes++;
    reset_n = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      e = '0;
      checks++; if (led !== e) $display("FAIL idle_led cyc=%0d got=%h exp=%h", i, led, e); else passes++;
      checks++; if (period_start !== (i % 16 == 0)) $display("FAIL idle_ps cyc=%0d got=%b exp=%b", i, period_start, (i % 16 == 0)); else passes++;
      checks++; if (pending !== 1'b0) $display("FAIL idle_pending cyc=%0d got=%b exp=0", i, pending); else passes++;
    end
    $display("test_reset done: %0d/%0d", passes, checks);
  endtask

  task automatic test_mid_load();
    logic [12:1] e;
    wait_ps();
    repeat (5) @(negedge clk);
    do_load(12'hFFF, 4'd4, 4'd12);
    checks++; if (pending !== 1'b1) $display("FAIL mid_pending_set got=%b exp=1", pending); else passes++;
    push_period(12'hFFF, 4, 12);
    wait_ps();
    checks++; if (pending !== 1'b0) $display("FAIL mid_pending_clr got=%b exp=0", pending); else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (led !== e) $display("FAIL mid_led step=%0d got=%h exp=%h", k, led, e); else passes++;
    end
    $display("test_mid_load done: %0d/%0d", passes, checks);
  endtask

  task automatic test_two_loads();
    logic [12:1] e;
    wait_ps();
    repeat (2) @(negedge clk);
    do_load(12'h001, 4'd3, 4'd0);
    repeat (3) @(negedge clk);
    do_load(12'h001, 4'd9, 4'd0);
    checks++; if (pending !== 1'b1) $display("FAIL two_pending_set got=%b exp=1", pending); else passes++;
    push_period(12'h001, 9, 0);
    wait_ps();
    checks++; if (pending !== 1'b0) $display("FAIL two_pending_clr got=%b exp=0", pending); else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (led !== e) $display("FAIL two_led step=%0d got=%h exp=%h", k, led, e); else passes++;
    end
    $display("test_two_loads done: %0d/%0d", passes, checks);
  endtask

  task automatic test_bypass();
    logic [12:1] e;
    wait_ps();
    repeat (15) @(negedge clk);
    push_period(12'h800, 0, 15);
    do_load(12'h800, 4'd0, 4'd15);
    checks++; if (period_start !== 1'b1) $display("FAIL bypass_aligned ps got=%b exp=1", period_start); else passes++;
    checks++; if (pending !== 1'b0) $display("FAIL bypass_pending got=%b exp=0", pending); else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (led !== e) $display("FAIL bypass_led step=%0d got=%h exp=%h", k, led, e); else passes++;
      checks++; if (pending !== 1'b0) $display("FAIL bypass_pending step=%0d got=%b exp=0", k, pending); else passes++;
    end
    $display("test_bypass done: %0d/%0d", passes, checks);
  endtask

  task automatic test_duty_zero();
    logic [12:1] e;
    wait_ps();
    repeat (3) @(negedge clk);
    do_load(12'h03F, 4'd0, 4'd9);
    push_period(12'h03F, 0, 9);
    wait_ps();
    checks++; if (pending !== 1'b0) $display("FAIL zero_pending got=%b exp=0", pending); else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (led !== e) $display("FAIL zero_led step=%0d got=%h exp=%h", k, led, e); else passes++;
    end
    $display("test_duty_zero done: %0d/%0d", passes, checks);
  endtask

  task automatic test_reset_mid();
    logic [12:1] e;
    wait_ps();
    repeat (2) @(negedge clk);
    do_load(12'hFFF, 4'd0, 4'd8);
    wait_ps();
    repeat (3) @(negedge clk);
    e = exp_led(12'hFFF, 0, 8, 2);
    checks++; if (led !== e) $display("FAIL rstmid_led_before got=%h exp=%h", led, e); else passes++;
    do_load(12'h0FF, 4'd5, 4'd5);
    checks++; if (pending !== 1'b1) $display("FAIL rstmid_pending_before got=%b exp=1", pending); else passes++;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (led !== 12'h000) $display("FAIL rstmid_led_async got=%h exp=000", led); else passes++;
    checks++; if (pending !== 1'b0) $display("FAIL rstmid_pending got=%b exp=0", pending); else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      checks++; if (led !== 12'h000) $display("FAIL rstmid_led_after cyc=%0d got=%h exp=000", i, led); else passes++;
      checks++; if (pending !== 1'b0) $display("FAIL rstmid_pending_after cyc=%0d got=%b exp=0", i, pending); else passes++;
    end
    $display("test_reset_mid done: %0d/%0d", passes, checks);
  endtask

  task automatic test_fade();
    logic [12:1] e;
    wait_ps();
    repeat (4) @(negedge clk);
    do_load(12'h001, 4'd5, 4'd0);
    for (int p = 1; p <= 5; p++) begin
      wait_ps();
      checks++; if (pending !== (p < 5)) $display("FAIL fade_pending period=%0d got=%b exp=%b", p, pending, (p < 5)); else passes++;
      push_period(12'h001, p, 0);
      for (int k = 0; k < 16; k++) begin
        if (k < 15) @(negedge clk);
        e = sb.pop_front();
        if (k < 15) begin
          checks++; if (led !== e) $display("FAIL fade_led period=%0d step=%0d got=%h exp=%h", p, k, led, e); else passes++;
        end
      end
    end
    $display("test_fade done: %0d/%0d", passes, checks);
  endtask

  initial begin
    test_reset();
`ifdef LED_PWM_FADE_EN
    test_fade();
`else
    test_mid_load();
    test_two_loads();
    test_bypass();
    test_duty_zero();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
